// File: rtl/wbuf_pkg.sv
// Shared types for the L2-to-memory write buffer: FSM states, line widths and the entry record.
// Optional in-place write coalescing is enabled by defining WBUF_COALESCE_EN.
package wbuf_pkg;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StResp,
    StDrain
  } wbuf_state_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/wbuf_store.sv
// Line FIFO for the write buffer: entry storage, head/tail/count, parallel address match.
// With WBUF_COALESCE_EN defined, a matching non-head entry can be overwritten in place.
module wbuf_store
  import wbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
`ifdef WBUF_COALESCE_EN
  input  logic              overwrite,
  output logic              co_hit,
`endif
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [PtrW:0]     count,
  output logic              full,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  entry_t          ent_q [DEPTH];
  logic [PtrW-1:0] head_q;
  logic [PtrW-1:0] tail_q;
  logic [PtrW:0]   count_q;
`ifdef WBUF_COALESCE_EN
  logic [PtrW-1:0] co_idx;
`endif

  // Scan oldest to newest so the last match found is the newest copy of the line.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx      = head_q;
    hit      = 1'b0;
    hit_data = '0;
`ifdef WBUF_COALESCE_EN
    co_hit   = 1'b0;
    co_idx   = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (ent_q[idx].valid && (ent_q[idx].addr == addr)) begin
        hit      = 1'b1;
        hit_data = ent_q[idx].data;
`ifdef WBUF_COALESCE_EN
        // The head may be in flight to memory, so it is never a coalesce target.
        if (i != 0) begin
          co_hit = 1'b1;
          co_idx = idx;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i].valid <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        ent_q[head_q].valid <= 1'b0;
        head_q              <= head_q + 1'b1;
      end
      // Push after pop: when full, a same-cycle push refills the slot just freed.
      if (push) begin
        ent_q[tail_q] <= '{valid: 1'b1, addr: addr, data: wdata};
        tail_q        <= tail_q + 1'b1;
      end
`ifdef WBUF_COALESCE_EN
      if (overwrite) begin
        ent_q[co_idx].data <= wdata;
      end
`endif
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign count     = count_q;
  assign full      = (count_q == (PtrW + 1)'(DEPTH));
  assign head_addr = ent_q[head_q].addr;
  assign head_data = ent_q[head_q].data;

endmodule

// File: rtl/l2_mem_write_buffer.sv
// Write buffer between the L2 D-side port and slow memory: absorbs write-backs, forwards read
// hits, issues read misses ahead of drains. Define WBUF_COALESCE_EN for in-place coalescing.
module l2_mem_write_buffer
  import wbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_read,
  input  logic              up_write,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic [DATA_W-1:0] up_wdata,
  output logic [DATA_W-1:0] up_rdata,
  output logic              up_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              wbuf_empty
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  wbuf_state_e       state_q, state_d;
  logic              up_ready_q, up_ready_d;
  logic [DATA_W-1:0] up_rdata_q, up_rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              push, pop;
  logic [CntW-1:0]   count;
  logic              full, hit;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data, hit_data;
  logic              wr_req, rd_req, drain_done;
`ifdef WBUF_COALESCE_EN
  logic              overwrite, co_hit;
`endif

  wbuf_store #(
    .DEPTH(DEPTH)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
`ifdef WBUF_COALESCE_EN
    .overwrite (overwrite),
    .co_hit    (co_hit),
`endif
    .addr      (up_addr),
    .wdata     (up_wdata),
    .count     (count),
    .full      (full),
    .head_addr (head_addr),
    .head_data (head_data),
    .hit       (hit),
    .hit_data  (hit_data)
  );

  // Writes only touch the buffer, so they are also taken while a drain is in flight.
  assign wr_req     = up_write && !up_ready_q && (state_q == StIdle || state_q == StDrain);
  assign rd_req     = up_read && !up_write && !up_ready_q && (state_q == StIdle);
  assign drain_done = (state_q == StDrain) && mem_ready;

  always_comb begin
    state_d     = state_q;
    up_ready_d  = 1'b0;
    up_rdata_d  = up_rdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    push        = 1'b0;
    pop         = 1'b0;
`ifdef WBUF_COALESCE_EN
    overwrite   = 1'b0;
`endif

    if (wr_req) begin
`ifdef WBUF_COALESCE_EN
      if (co_hit) begin
        overwrite  = 1'b1;
        up_ready_d = 1'b1;
      end else if (!full || drain_done) begin
        push       = 1'b1;
        up_ready_d = 1'b1;
      end
`else
      if (!full || drain_done) begin
        push       = 1'b1;
        up_ready_d = 1'b1;
      end
`endif
    end

    unique case (state_q)
      StIdle: begin
        if (rd_req && !hit) begin
          state_d    = StFill;
          mem_read_d = 1'b1;
          mem_addr_d = up_addr;
        end else begin
          if (rd_req) begin
            up_ready_d = 1'b1;
            up_rdata_d = hit_data;
          end
          // Skip the completion cycle so L2's next request is seen before a drain locks us out.
          if (count != '0 && !up_ready_q) begin
            state_d     = StDrain;
            mem_write_d = 1'b1;
            mem_addr_d  = head_addr;
            mem_wdata_d = head_data;
          end
        end
      end
      StFill: begin
        if (mem_ready) begin
          state_d    = StResp;
          mem_read_d = 1'b0;
          up_rdata_d = mem_rdata;
          up_ready_d = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      StDrain: begin
        if (mem_ready) begin
          state_d     = StIdle;
          mem_write_d = 1'b0;
          pop         = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      up_ready_q  <= 1'b0;
      up_rdata_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      up_ready_q  <= up_ready_d;
      up_rdata_q  <= up_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign up_ready   = up_ready_q;
  assign up_rdata   = up_rdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign wbuf_empty = (count == '0);

endmodule
